rns_wb_convert: RTL

Multi-cycle residue-to-binary converter in the writeback path of the 8-bit RISC RNS processor. It sits directly downstream of the EX stage. It takes a result in the {8,7,9} residue system plus its destination register address, and reconstructs the binary value by mixed-radix conversion (MRC). It delivers 8-bit write data and the address to the register file over a valid/ready handshake.

---
 rtl/rns_pkg.sv | 35 +++
 rtl/rns_mod_sub.sv | 17 +
 rtl/rns_wb_convert.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rns_pkg.sv
// Shared constants, FSM state type and modular helper for the {8,7,9} RNS writeback converter.
package rns_pkg;

    localparam int M1 = 8;
    localparam int M2 = 7;
    localparam int M3 = 9;

    localparam int INV_8_MOD7 = 1;
    localparam int INV_8_MOD9 = 8;
    localparam int INV_7_MOD9 = 4;

    // Mixed-radix weights: x = v1 + 8*v2 + 56*v3
    localparam int MR_W2 = 8;
    localparam int MR_W3 = 56;

    localparam int R8_W   = 3;
    localparam int R7_W   = 3;
    localparam int R9_W   = 4;
    localparam int RD_W   = 3;
    localparam int FULL_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        V2,
        V3,
        ACC,
        DONE
    } state_t;

    // Constant-coefficient modular product; operands are small so this stays a tiny table.
    function automatic int mul_mod(input int a, input int k, input int m);
        return (a * k) % m;
    endfunction

endpackage

// File: rtl/rns_mod_sub.sv
// (a - b) mod M for operands already reduced into [0, M-1].
module rns_mod_sub #(
    parameter int M = 7,
    parameter int W = $clog2(M)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d
);

    logic [W:0] diff;

    // A borrow out of the top bit means the difference went negative; fold it back by adding M.
    assign diff = {1'b0, a} - {1'b0, b};
    assign d    = diff[W] ? diff[W-1:0] + W'(M) : diff[W-1:0];

endmodule

// File: rtl/rns_wb_convert.sv
// Residue {8,7,9} to binary writeback converter using mixed-radix conversion.
// Build option: define RNS_WB_SAT_EN to saturate out_data on overflow instead of wrapping.
module rns_wb_convert
    import rns_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_r8,
    input  logic [2:0]        in_r7,
    input  logic [3:0]        in_r9,
    input  logic [2:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [8:0]        out_full,
    output logic [2:0]        out_rd,
    output logic              out_ovf,
    output logic              out_err
);

    localparam logic [9:0] OUT_MAX = 10'((1 << OUT_W) - 1);

    state_t state, state_nxt;

    logic [R8_W-1:0]   v1;
    logic [R7_W-1:0]   r7_q, v2;
    logic [R9_W-1:0]   r9_q, v3;
    logic [RD_W-1:0]   rd_q;
    logic              err_q;

    logic              capture;
    logic [R7_W-1:0]   d7, v2_nxt;
    logic [R9_W-1:0]   d9a, t9, d9b, v3_nxt;
    logic [FULL_W-1:0] full_nxt;
    logic              ovf_nxt;
    logic [OUT_W-1:0]  data_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign capture   = (state == IDLE) && in_valid && !flush;

    // v2 = (r7 - v1) * inv(8) mod 7
    rns_mod_sub #(.M(M2)) u_sub7 (
        .a (r7_q),
        .b (v1),
        .d (d7)
    );
    assign v2_nxt = R7_W'(mul_mod(int'(d7), INV_8_MOD7, M2));

    // v3 = (((r9 - v1) * inv(8) mod 9) - v2) * inv(7) mod 9
    rns_mod_sub #(.M(M3)) u_sub9_a (
        .a (r9_q),
        .b ({1'b0, v1}),
        .d (d9a)
    );
    assign t9 = R9_W'(mul_mod(int'(d9a), INV_8_MOD9, M3));

    rns_mod_sub #(.M(M3)) u_sub9_b (
        .a (t9),
        .b ({1'b0, v2}),
        .d (d9b)
    );
    assign v3_nxt = R9_W'(mul_mod(int'(d9b), INV_7_MOD9, M3));

    assign full_nxt = FULL_W'(v1)
                    + FULL_W'(v2) * FULL_W'(MR_W2)
                    + FULL_W'(v3) * FULL_W'(MR_W3);
    assign ovf_nxt  = {1'b0, full_nxt} > OUT_MAX;

`ifdef RNS_WB_SAT_EN
    assign data_nxt = ovf_nxt ? {OUT_W{1'b1}} : full_nxt[OUT_W-1:0];
`else
    assign data_nxt = full_nxt[OUT_W-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = V2;
                V2:      state_nxt = V3;
                V3:      state_nxt = ACC;
                ACC:     state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: datapath registers are reset too, so outputs read 0 after reset and a discarded operation leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= '0;
            r7_q     <= '0;
            r9_q     <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            v2       <= '0;
            v3       <= '0;
            out_full <= '0;
            out_data <= '0;
            out_rd   <= '0;
            out_ovf  <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (capture) begin
                v1    <= in_r8;
                r7_q  <= in_r7;
                r9_q  <= in_r9;
                rd_q  <= in_rd;
                err_q <= (in_r7 == 3'd7) || (in_r9 > 4'd8);
            end
            if (state == V2 && !flush) v2 <= v2_nxt;
            if (state == V3 && !flush) v3 <= v3_nxt;
            if (state == ACC && !flush) begin
                out_rd <= rd_q;
                if (err_q) begin
                    out_full <= '0;
                    out_data <= '0;
                    out_ovf  <= 1'b0;
                    out_err  <= 1'b1;
                end else begin
                    out_full <= full_nxt;
                    out_data <= data_nxt;
                    out_ovf  <= ovf_nxt;
                    out_err  <= 1'b0;
                end
            end
        end
    end

endmodule
